// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer for the multi-cycle RV32I core: runs the fetch
// handshake, selects the next PC on retirement and counts retired instructions.
module pc_fetch_ctrl #(
    parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0100,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic        misalign_trap,
    output logic        bus_error,
    output logic        halted,
    output logic [31:0] instret
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   instret_q, instret_d;
    logic          instr_valid_q, instr_valid_d;
    logic          misalign_q, misalign_d;
    logic          bus_error_q, bus_error_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          timeout_hit;

    // True while the current FETCH cycle is the last one allowed before giving up.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instret_d     = instret_q;
        instr_valid_d = 1'b0;
        misalign_d    = 1'b0;
        bus_error_d   = bus_error_q;
        tcnt_d        = tcnt_q;
        next_pc       = pc;
        imem_req      = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    tcnt_d        = '0;
                    state_d       = S_EXEC;
                end else if (timeout_hit) begin
                    bus_error_d = 1'b1;
                    tcnt_d      = '0;
                    state_d     = S_HALT;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    instret_d = instret_q + 32'd1;
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_FETCH;
                        if (redirect) begin
                            if (redirect_target[1:0] == 2'b00) begin
                                next_pc = redirect_target;
                            end else begin
                                next_pc    = TRAP_VECTOR;
                                misalign_d = 1'b1;
                            end
                        end else begin
                            next_pc = pc + 32'd4;
                        end
                    end
                end
            end
            S_HALT: begin
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset is asynchronous, so the bus request must drop in the same cycle.
        if (reset) begin
            imem_req = 1'b0;
            next_pc  = pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            instr_q       <= '0;
            instret_q     <= '0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            bus_error_q   <= 1'b0;
            tcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instret_q     <= instret_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
            bus_error_q   <= bus_error_d;
            tcnt_q        <= tcnt_d;
        end
    end

    assign imem_addr     = pc;
    assign halted        = (state_q == S_HALT);
    assign instr         = instr_q;
    assign instr_valid   = instr_valid_q;
    assign misalign_trap = misalign_q;
    assign bus_error     = bus_error_q;
    assign instret       = instret_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl: an instruction-level reference model
// predicts fetch addresses, next-PC choices, pulses and the retire count.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        halt_req = 1'b0;
    logic        misalign_trap;
    logic        bus_error;
    logic        halted;
    logic [31:0] instret;

    logic        pc_load = 1'b0;
    logic [31:0] pc_load_val = '0;

    int          checks = 0;
    int          errors = 0;

    // Reference model state
    logic [31:0] model_pc = '0;
    logic [31:0] exp_instret = '0;
    logic        iv_pending = 1'b0;
    logic        mis_pending = 1'b0;
    logic        exp_berr = 1'b0;

    localparam logic [31:0] TRAP = 32'h0000_0100;

    pc_fetch_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .next_pc         (next_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .exec_done       (exec_done),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .misalign_trap   (misalign_trap),
        .bus_error       (bus_error),
        .halted          (halted),
        .instret         (instret)
    );

    always #5 clk = ~clk;

    // The PC register owned by the surrounding core, with a test-only load port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        pc <= '0;
        else if (pc_load) pc <= pc_load_val;
        else              pc <= next_pc;
    end

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and compare every registered output with the model.
    task automatic step();
        @(posedge clk);
        #1;
        check32("instr_valid", {31'd0, instr_valid}, {31'd0, iv_pending});
        check32("misalign_trap", {31'd0, misalign_trap}, {31'd0, mis_pending});
        check32("instret", instret, exp_instret);
        check32("bus_error", {31'd0, bus_error}, {31'd0, exp_berr});
        iv_pending  = 1'b0;
        mis_pending = 1'b0;
    endtask

    task automatic noise_exec_inputs();
        exec_done       = 1'($urandom % 2);
        redirect        = 1'($urandom % 2);
        halt_req        = 1'($urandom % 2);
        redirect_target = $urandom;
    endtask

    task automatic clear_model();
        model_pc    = '0;
        exp_instret = '0;
        iv_pending  = 1'b0;
        mis_pending = 1'b0;
        exp_berr    = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        redirect  = 1'b0;
        halt_req  = 1'b0;
        clear_model();
        step();
        check32("rst_req", {31'd0, imem_req}, 32'd0);
        check32("rst_next_pc", next_pc, pc);
        check32("rst_pc", pc, 32'd0);
        check32("rst_instr", instr, 32'd0);
        check32("rst_halted", {31'd0, halted}, 32'd0);
        step();
        reset = 1'b0;
    endtask

    // One instruction from fetch to retirement.
    task automatic do_instr(input int ack_dly, input int exec_dly, input bit red,
                            input logic [31:0] tgt, input bit hlt);
        logic [31:0] rdata;
        logic [31:0] exp_next;
        rdata = $urandom;
        for (int k = 0; k < ack_dly; k++) begin
            imem_ack = 1'b0;
            noise_exec_inputs();
            #1;
            check32("fetch_req", {31'd0, imem_req}, 32'd1);
            check32("fetch_addr", imem_addr, model_pc);
            check32("fetch_next_pc", next_pc, model_pc);
            step();
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        noise_exec_inputs();
        #1;
        check32("ack_req", {31'd0, imem_req}, 32'd1);
        check32("ack_addr", imem_addr, model_pc);
        iv_pending = 1'b1;
        step();
        check32("instr", instr, rdata);
        exec_done = 1'b0;
        for (int k = 0; k < exec_dly; k++) begin
            imem_ack        = 1'($urandom % 2);
            redirect        = 1'($urandom % 2);
            halt_req        = 1'($urandom % 2);
            redirect_target = $urandom;
            #1;
            check32("exec_hold_next_pc", next_pc, model_pc);
            check32("exec_req", {31'd0, imem_req}, 32'd0);
            step();
        end
        if (hlt)                   exp_next = model_pc;
        else if (!red)             exp_next = model_pc + 32'd4;
        else if (tgt[1:0] == 2'b0) exp_next = tgt;
        else                       exp_next = TRAP;
        imem_ack        = 1'($urandom % 2);
        exec_done       = 1'b1;
        redirect        = red;
        halt_req        = hlt;
        redirect_target = tgt;
        #1;
        check32("retire_next_pc", next_pc, exp_next);
        exp_instret = exp_instret + 32'd1;
        mis_pending = !hlt && red && (tgt[1:0] != 2'b0);
        step();
        exec_done = 1'b0;
        redirect  = 1'b0;
        halt_req  = 1'b0;
        imem_ack  = 1'b0;
        check32("pc_after_retire", pc, exp_next);
        check32("halted_after_retire", {31'd0, halted}, {31'd0, hlt});
        $display("instr pc=%h rdata=%h red=%0d tgt=%h hlt=%0d next=%h instret=%0d",
                 model_pc, rdata, red, tgt, hlt, exp_next, exp_instret);
        model_pc = exp_next;
    endtask

    initial begin
        logic [31:0] tmp;
        logic [31:0] tgt;
        int          kind;

        do_reset();

        // Sequential NOP stream: addresses 0,4,8,12 and four retirements.
        for (int i = 0; i < 4; i++) do_instr(2, 0, 1'b0, 32'h0, 1'b0);
        check32("instret_after4", instret, 32'd4);

        do_instr(1, 1, 1'b1, 32'h0000_0040, 1'b0);
        do_instr(0, 0, 1'b1, 32'h0000_0042, 1'b0);
        check32("trap_fetch_addr", imem_addr, TRAP);

        // Randomized instruction stream.
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom % 10);
            tmp  = $urandom;
            if (kind < 5) begin
                do_instr(int'($urandom % 7), int'($urandom % 4), 1'b0, tmp, 1'b0);
            end else if (kind < 8) begin
                tgt = {tmp[31:2], 2'b00};
                do_instr(int'($urandom % 7), int'($urandom % 4), 1'b1, tgt, 1'b0);
            end else begin
                tgt = {tmp[31:2], 2'(1 + ($urandom % 3))};
                do_instr(int'($urandom % 7), int'($urandom % 4), 1'b1, tgt, 1'b0);
            end
        end

        // Reset asserted mid-FETCH: request drops at once, retire count clears.
        imem_ack = 1'b0;
        #1;
        check32("pre_reset_req", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check32("midfetch_req", {31'd0, imem_req}, 32'd0);
        check32("midfetch_instret", instret, 32'd0);
        clear_model();
        step();
        reset = 1'b0;

        // Halt wins over redirect; everything frozen until reset.
        do_instr(1, 0, 1'b1, 32'h0000_0200, 1'b0);
        do_instr(2, 1, 1'b1, 32'h0000_0080, 1'b1);
        for (int k = 0; k < 50; k++) begin
            imem_ack = 1'($urandom % 2);
            noise_exec_inputs();
            #1;
            check32("halt_req_low", {31'd0, imem_req}, 32'd0);
            check32("halt_hold", next_pc, pc);
            check32("halt_halted", {31'd0, halted}, 32'd1);
            step();
            check32("halt_pc", pc, model_pc);
        end
        do_reset();
        do_instr(0, 0, 1'b0, 32'h0, 1'b0);

        // Fetch timeout: 16 unanswered FETCH cycles end in HALT with bus_error.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            imem_ack = 1'b0;
            noise_exec_inputs();
            #1;
            check32("to_req", {31'd0, imem_req}, 32'd1);
            if (k == 15) exp_berr = 1'b1;
            step();
            check32("to_halted", {31'd0, halted}, (k == 15) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 5; k++) begin
            imem_ack = 1'($urandom % 2);
            #1;
            check32("to_halt_req", {31'd0, imem_req}, 32'd0);
            step();
        end

        // Ack on the 16th cycle is still accepted.
        do_reset();
        do_instr(15, 0, 1'b0, 32'h0, 1'b0);
        do_instr(3, 0, 1'b0, 32'h0, 1'b0);

        // Sequential wrap at the top of the address space.
        pc_load     = 1'b1;
        pc_load_val = 32'hFFFF_FFFC;
        imem_ack    = 1'b0;
        step();
        pc_load  = 1'b0;
        model_pc = 32'hFFFF_FFFC;
        do_instr(2, 0, 1'b0, 32'h0, 1'b0);
        check32("wrap_pc", pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
